decode_writeback: RTL and testbench
===================================

DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 SHALL have parameter RNONE, default 4'hF, the register ID meaning "no register".
REQ-002 SHALL have parameter RSP, default 4'h4, the stack pointer register ID.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port icode  input  4  opcode of the current instruction.
REQ-006 SHALL have ports rA and rB  input  4 each  register specifiers from fetch.
REQ-007 SHALL have port cnd  input  1  condition from the execute stage; gates the cmovXX write.
REQ-008 SHALL have ports valE and valM  input  64 each  ALU result and memory read data to write back.
REQ-009 SHALL have port wb_en  input  1  commits write-back this cycle.
REQ-010 SHALL have ports valA and valB  output  64 each  operands to the execute stage.
REQ-011 SHALL have ports srcA, srcB, dstE and dstM  output  4 each  decoded register IDs.
REQ-012 SHALL have port halted  output  1  sticky halt status.

Function
REQ-013 SHALL hold 15 architectural 64-bit registers, IDs 0..14; ID RNONE has no storage.
REQ-014 SHALL decode srcA as rA for icode 2, 4, 6 and A; as RSP for icode 9 and B; otherwise RNONE.
REQ-015 SHALL decode srcB as rB for icode 4, 5 and 6; as RSP for icode 8, 9, A and B; otherwise RNONE.
REQ-016 SHALL decode dstE as rB for icode 3 and 6, and for icode 2 when cnd=1; as RSP for icode 8, 9, A and B; otherwise RNONE.
REQ-017 SHALL decode dstM as rA for icode 5 and B; otherwise RNONE.
REQ-018 SHALL drive valA and valB combinationally from the register file, with zero latency, and SHALL drive 0 when the source ID is RNONE.
REQ-019 SHALL NOT bypass a same-cycle write to valA or valB; reads return the pre-edge value.
REQ-020 SHALL, on the rising edge with wb_en=1 and halted=0, write valE to dstE and valM to dstM when each is not RNONE.
REQ-021 SHALL, when dstE equals dstM and neither is RNONE, store valM (popq %rsp semantics).
REQ-022 SHALL ignore rA/rB values of RNONE as write targets; no register changes.
REQ-023 SHALL set halted on the rising edge with wb_en=1 and icode=0; halted stays set until reset.
REQ-024 SHALL block all register writes while halted=1; reads remain functional.
REQ-025 SHALL treat undefined icode values C..F as no-ops: srcA, srcB, dstE and dstM all RNONE, with no writes.

Reset
REQ-026 SHALL, on a rising edge with rst_n=0, clear all 15 registers to 0 and clear halted to 0, overriding wb_en.
REQ-027 SHALL make valA and valB read 0 in the cycle after reset for every source ID.
REQ-028 SHALL, when reset is asserted in the same cycle as a write, discard the write.

Structure
REQ-029 SHALL take the icode constants (HALT=0 through POPQ=B), RNONE and RSP from a shared package y86_pkg, which the execute stage also uses.
REQ-030 SHALL place the storage in one sub-module, regfile, with 2 read ports and 2 write ports; decode, priority and halt logic stay in decode_writeback.

Verification
REQ-031 SHALL cover: irmovq with icode=3, rB=2, valE=1234 and wb_en=1 -> next cycle, icode=6, rA=2 gives srcA=2 and valA=1234.
REQ-032 SHALL cover: cmovXX with icode=2, rB=3, valE=77, cnd=0 -> dstE=F and reg3 is unchanged; repeat with cnd=1 -> reg3=77.
REQ-033 SHALL cover: popq %rsp with icode=B, rA=4, valE=0x108, valM=0x55 -> reg4=0x55 after the edge.
REQ-034 SHALL cover: pushq with icode=A, rA=1 and reg4=0x200 -> srcA=1, srcB=4, valB=0x200, dstE=4; with valE=0x1F8 -> reg4=0x1F8.
REQ-035 SHALL cover: icode=0 with wb_en=1 -> halted=1; a following irmovq to reg5 with valE=9 -> reg5 stays 0.
REQ-036 SHALL cover: rst_n=0 for one edge after loading reg7=0xDEAD with halted=1 -> reg7=0 and halted=0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, special register IDs and the
// decode_writeback status encoding. Also used by the execute stage.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [3:0] R_RSP  = 4'h4;

  localparam int NUM_REGS = 15;

  // Run/halt status; HALT is sticky until reset.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } dec_ids_t;

endpackage

// File: rtl/regfile.sv
// Y86-64 register file: 15 x 64-bit, two combinational read ports and two
// write ports (E and M). When both ports target the same register, M wins.
module regfile
  import y86_pkg::*;
#(
  parameter logic [3:0] RNONE = R_NONE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  ra_addr,
  output logic [63:0] ra_data,
  input  logic [3:0]  rb_addr,
  output logic [63:0] rb_data,
  input  logic        we_e,
  input  logic [3:0]  wa_e,
  input  logic [63:0] wd_e,
  input  logic        we_m,
  input  logic [3:0]  wa_m,
  input  logic [63:0] wd_m
);

  localparam logic [3:0] LAST_ID = 4'(NUM_REGS - 1);

  logic [63:0] regs [NUM_REGS];

  logic ra_ok, rb_ok, wa_e_ok, wa_m_ok;

  assign ra_ok   = (ra_addr != RNONE) && (ra_addr <= LAST_ID);
  assign rb_ok   = (rb_addr != RNONE) && (rb_addr <= LAST_ID);
  assign wa_e_ok = we_e && (wa_e != RNONE) && (wa_e <= LAST_ID);
  assign wa_m_ok = we_m && (wa_m != RNONE) && (wa_m <= LAST_ID);

  // Reads see the pre-edge contents; no write-to-read bypass.
  assign ra_data = ra_ok ? regs[ra_addr] : 64'd0;
  assign rb_data = rb_ok ? regs[rb_addr] : 64'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 64'd0;
      end
    end else begin
      if (wa_e_ok) regs[wa_e] <= wd_e;
      // Issued last so a popq %rsp collision keeps valM.
      if (wa_m_ok) regs[wa_m] <= wd_m;
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode and write-back stage: derives source/destination register IDs
// from the opcode, reads operands, commits results and tracks the halt status.
module decode_writeback
  import y86_pkg::*;
#(
  parameter logic [3:0] RNONE = R_NONE,
  parameter logic [3:0] RSP   = R_RSP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        wb_en,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic        halted
);

  dec_ids_t  ids;
  wb_state_e state, state_nxt;
  logic      commit;

  always_comb begin
    ids.src_a = RNONE;
    ids.src_b = RNONE;
    ids.dst_e = RNONE;
    ids.dst_m = RNONE;
    case (icode)
      I_RRMOVQ: begin
        ids.src_a = rA;
        if (cnd) ids.dst_e = rB;
      end
      I_IRMOVQ: ids.dst_e = rB;
      I_RMMOVQ: begin
        ids.src_a = rA;
        ids.src_b = rB;
      end
      I_MRMOVQ: begin
        ids.src_b = rB;
        ids.dst_m = rA;
      end
      I_OPQ: begin
        ids.src_a = rA;
        ids.src_b = rB;
        ids.dst_e = rB;
      end
      I_CALL: begin
        ids.src_b = RSP;
        ids.dst_e = RSP;
      end
      I_RET: begin
        ids.src_a = RSP;
        ids.src_b = RSP;
        ids.dst_e = RSP;
      end
      I_PUSHQ: begin
        ids.src_a = rA;
        ids.src_b = RSP;
        ids.dst_e = RSP;
      end
      I_POPQ: begin
        ids.src_a = RSP;
        ids.src_b = RSP;
        ids.dst_e = RSP;
        ids.dst_m = rA;
      end
      default: ;
    endcase
  end

  assign srcA = ids.src_a;
  assign srcB = ids.src_b;
  assign dstE = ids.dst_e;
  assign dstM = ids.dst_m;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (wb_en && (icode == I_HALT)) state_nxt = ST_HALT;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  assign halted = (state == ST_HALT);
  assign commit = wb_en && (state == ST_RUN);

  regfile #(.RNONE(RNONE)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (ids.src_a),
    .ra_data (valA),
    .rb_addr (ids.src_b),
    .rb_data (valB),
    .we_e    (commit),
    .wa_e    (ids.dst_e),
    .wd_e    (valE),
    .we_m    (commit),
    .wa_m    (ids.dst_m),
    .wd_m    (valM)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed scenarios plus random
// instruction streams compared against a behavioural register-file model.
module tb_decode_writeback;

  logic        clk;
  logic        rst_n;
  logic [3:0]  icode, rA, rB;
  logic        cnd;
  logic [63:0] valE, valM;
  logic        wb_en;
  logic [63:0] valA, valB;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_regs [15];
  logic        m_halt;

  decode_writeback dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .icode  (icode),
    .rA     (rA),
    .rB     (rB),
    .cnd    (cnd),
    .valE   (valE),
    .valM   (valM),
    .wb_en  (wb_en),
    .valA   (valA),
    .valB   (valB),
    .srcA   (srcA),
    .srcB   (srcB),
    .dstE   (dstE),
    .dstM   (dstM),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode rules, stated as opcode sets.
  function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    if (ic inside {4'h3, 4'h6}) return rb;
    if (ic == 4'h2 && c) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] id);
    if (id == 4'hF) return 64'd0;
    return m_regs[id];
  endfunction

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm,
                       input logic we);
    @(negedge clk);
    icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm; wb_en = we;
    #1;
  endtask

  // Advance one edge and apply the architectural effect of the current inputs.
  task automatic commit();
    logic [3:0] e, m;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
      m_halt = 1'b0;
    end else if (wb_en && !m_halt) begin
      e = m_dst_e(icode, rB, cnd);
      m = m_dst_m(icode, rA);
      if (e != 4'hF) m_regs[e] = valE;
      if (m != 4'hF) m_regs[m] = valM;
      if (icode == 4'h0) m_halt = 1'b1;
    end
    #1;
  endtask

  task automatic read_reg(input logic [3:0] r, output logic [63:0] v);
    drive(4'h6, r, r, 1'b0, 64'd0, 64'd0, 1'b0);
    v = valA;
    commit();
  endtask

  task automatic test_reset();
    logic [63:0] v;
    rst_n = 1'b0;
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h99, 64'h0, 1'b1);
    commit();
    rst_n = 1'b1;
    for (int r = 0; r < 16; r++) begin
      read_reg(4'(r), v);
      n_checks++;
      if (v !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h expected 0", r, v);
      end
    end
    n_checks++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_halted: got %b expected 0", halted);
    end
  endtask

  task automatic test_irmovq_opq();
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'd1234, 64'd0, 1'b1);
    n_checks++;
    if (dstE !== 4'h2) begin
      n_fail++;
      $display("FAIL irmovq_dstE: got %h expected 2", dstE);
    end
    commit();
    drive(4'h6, 4'h2, 4'h0, 1'b0, 64'd0, 64'd0, 1'b0);
    n_checks++;
    if (srcA !== 4'h2) begin
      n_fail++;
      $display("FAIL opq_srcA: got %h expected 2", srcA);
    end
    n_checks++;
    if (valA !== 64'd1234) begin
      n_fail++;
      $display("FAIL opq_valA: got %0d expected 1234", valA);
    end
    commit();
  endtask

  task automatic test_cmov();
    logic [63:0] v;
    drive(4'h2, 4'h1, 4'h3, 1'b0, 64'd77, 64'd0, 1'b1);
    n_checks++;
    if (dstE !== 4'hF) begin
      n_fail++;
      $display("FAIL cmov_nc_dstE: got %h expected f", dstE);
    end
    commit();
    read_reg(4'h3, v);
    n_checks++;
    if (v !== 64'd0) begin
      n_fail++;
      $display("FAIL cmov_nc_reg3: got %0d expected 0", v);
    end
    drive(4'h2, 4'h1, 4'h3, 1'b1, 64'd77, 64'd0, 1'b1);
    commit();
    read_reg(4'h3, v);
    n_checks++;
    if (v !== 64'd77) begin
      n_fail++;
      $display("FAIL cmov_c_reg3: got %0d expected 77", v);
    end
  endtask

  task automatic test_popq_rsp();
    logic [63:0] v;
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h55, 1'b1);
    n_checks++;
    if (dstE !== 4'h4 || dstM !== 4'h4) begin
      n_fail++;
      $display("FAIL popq_dst: got E=%h M=%h expected 4 4", dstE, dstM);
    end
    commit();
    read_reg(4'h4, v);
    n_checks++;
    if (v !== 64'h55) begin
      n_fail++;
      $display("FAIL popq_rsp_reg4: got %h expected 55", v);
    end
  endtask

  task automatic test_pushq();
    logic [63:0] v;
    drive(4'h3, 4'hF, 4'h4, 1'b0, 64'h200, 64'd0, 1'b1);
    commit();
    drive(4'hA, 4'h1, 4'hF, 1'b0, 64'h1F8, 64'd0, 1'b1);
    n_checks++;
    if (srcA !== 4'h1 || srcB !== 4'h4 || dstE !== 4'h4) begin
      n_fail++;
      $display("FAIL pushq_ids: got srcA=%h srcB=%h dstE=%h expected 1 4 4", srcA, srcB, dstE);
    end
    n_checks++;
    if (valB !== 64'h200) begin
      n_fail++;
      $display("FAIL pushq_valB: got %h expected 200", valB);
    end
    commit();
    read_reg(4'h4, v);
    n_checks++;
    if (v !== 64'h1F8) begin
      n_fail++;
      $display("FAIL pushq_reg4: got %h expected 1f8", v);
    end
  endtask

  task automatic test_halt_then_reset();
    logic [63:0] v;
    drive(4'h3, 4'hF, 4'h7, 1'b0, 64'hDEAD, 64'd0, 1'b1);
    commit();
    drive(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
    commit();
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_set: got %b expected 1", halted);
    end
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'd9, 64'd0, 1'b1);
    commit();
    read_reg(4'h5, v);
    n_checks++;
    if (v !== 64'd0) begin
      n_fail++;
      $display("FAIL halt_blocks_write: got %0d expected 0", v);
    end
    read_reg(4'h7, v);
    n_checks++;
    if (v !== 64'hDEAD || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_read_reg7: got %h halted=%b expected dead 1", v, halted);
    end
    rst_n = 1'b0;
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
    commit();
    rst_n = 1'b1;
    read_reg(4'h7, v);
    n_checks++;
    if (v !== 64'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after_halt: got reg7=%h halted=%b expected 0 0", v, halted);
    end
  endtask

  task automatic test_random();
    logic [3:0]  ic, ra, rb;
    logic        c, we;
    logic [63:0] ve, vm, v;
    for (int n = 0; n < 300; n++) begin
      ic = 4'($urandom_range(1, 15));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      c  = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 3) != 0);
      ve = {$urandom, $urandom};
      vm = {$urandom, $urandom};
      drive(ic, ra, rb, c, ve, vm, we);
      n_checks++;
      if (srcA !== m_src_a(ic, ra) || srcB !== m_src_b(ic, rb)) begin
        n_fail++;
        $display("FAIL rand_src icode=%h: got %h %h expected %h %h", ic, srcA, srcB,
                 m_src_a(ic, ra), m_src_b(ic, rb));
      end
      n_checks++;
      if (dstE !== m_dst_e(ic, rb, c) || dstM !== m_dst_m(ic, ra)) begin
        n_fail++;
        $display("FAIL rand_dst icode=%h: got %h %h expected %h %h", ic, dstE, dstM,
                 m_dst_e(ic, rb, c), m_dst_m(ic, ra));
      end
      n_checks++;
      if (valA !== m_read(m_src_a(ic, ra)) || valB !== m_read(m_src_b(ic, rb))) begin
        n_fail++;
        $display("FAIL rand_val icode=%h: got %h %h expected %h %h", ic, valA, valB,
                 m_read(m_src_a(ic, ra)), m_read(m_src_b(ic, rb)));
      end
      commit();
    end
    for (int r = 0; r < 15; r++) begin
      read_reg(4'(r), v);
      n_checks++;
      if (v !== m_regs[r]) begin
        n_fail++;
        $display("FAIL rand_final_reg%0d: got %h expected %h", r, v, m_regs[r]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    valE = 64'd0; valM = 64'd0; wb_en = 1'b0;
    m_halt = 1'b0;
    for (int i = 0; i < 15; i++) m_regs[i] = 64'hX;
    test_reset();
    test_irmovq_opq();
    test_cmov();
    test_popq_rsp();
    test_pushq();
    test_halt_then_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
